cache_write_combine_ctrl: RTL and testbench

//   Write-combining controller between processor store port and D-cache line-write port.

---
 rtl/cache_write_combine_ctrl.sv | 143 ++++++++++++++
 tb/tb_cache_write_combine_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_combine_ctrl.sv
// Write-combining controller: merges word stores into a 128-bit line buffer and
// drains it to the D-cache as one masked line write.
//
// state | meaning
// IDLE  | buffer empty, any store accepted and starts a new line
// MERGE | partial line held, same-line stores merged
// DRAIN | line write presented to cache, waiting for m_ready
module cache_write_combine_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         p_req,
   output logic         p_ready,
   input  logic [31:0]  p_addr,
   input  logic [3:0]   p_w_en,
   input  logic [31:0]  p_wdata,
   input  logic         flush,
   output logic         idle,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_addr,
   output logic [127:0] m_data,
   output logic [15:0]  m_strb
);

   typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, DRAIN = 2'd2} state_t;

   state_t         state, state_next;
   logic [127:0]   line_data, merged_data;
   logic [15:0]    strb, merged_strb;
   logic [27:0]    tag;
   logic [CNT_W-1:0] cnt;
   logic           drain_pend;
   logic           accept, store_eff, tag_hit, line_full, timeout_hit, go_drain;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^p_addr[1:0];

   assign tag_hit     = (p_addr[31:4] == tag);
   assign accept      = p_req & p_ready;
   assign store_eff   = accept & (p_w_en != 4'h0);
   assign line_full   = (merged_strb == 16'hFFFF);
   assign timeout_hit = (TIMEOUT != 0) && !accept && (cnt == CNT_W'(TIMEOUT - 1));

   // Byte placement: word offset selects the 4-byte lane, mask selects bytes within it.
   always_comb begin
      merged_data = line_data;
      merged_strb = strb;
      if (accept) begin
         for (int b = 0; b < 4; b++) begin
            if (p_w_en[b]) begin
               merged_data[{p_addr[3:2], 2'(b), 3'b000} +: 8] = p_wdata[8*b +: 8];
               merged_strb[{p_addr[3:2], 2'(b)}]              = 1'b1;
            end
         end
      end
   end

   assign go_drain = drain_pend | line_full | flush | (p_req & ~tag_hit) | timeout_hit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (store_eff) state_next = MERGE;
         MERGE:   if (go_drain) state_next = DRAIN;
         DRAIN:   if (m_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      p_ready = 1'b0;
      idle    = 1'b0;
      case (state)
         IDLE:    begin p_ready = 1'b1; idle = 1'b1; end
         MERGE:   p_ready = tag_hit;
         default: p_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         line_data  <= '0;
         strb       <= '0;
         tag        <= '0;
         cnt        <= '0;
         drain_pend <= 1'b0;
         m_valid    <= 1'b0;
         m_addr     <= '0;
         m_data     <= '0;
         m_strb     <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (store_eff) begin
                  tag        <= p_addr[31:4];
                  line_data  <= merged_data;
                  strb       <= merged_strb;
                  // Flush or full line on the opening store drains one cycle later.
                  drain_pend <= flush | line_full;
               end
            end
            MERGE: begin
               drain_pend <= 1'b0;
               if (accept) begin
                  line_data <= merged_data;
                  strb      <= merged_strb;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               if (go_drain) begin
                  m_valid <= 1'b1;
                  m_addr  <= {tag, 4'b0000};
                  m_data  <= merged_data;
                  m_strb  <= merged_strb;
               end
            end
            DRAIN: begin
               if (m_ready) begin
                  line_data <= '0;
                  strb      <= '0;
                  cnt       <= '0;
                  m_valid   <= 1'b0;
                  m_addr    <= '0;
                  m_data    <= '0;
                  m_strb    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_write_combine_ctrl.sv
// Directed bench for cache_write_combine_ctrl: stores, flush, line change,
// idle timeout, reset during drain and idle no-ops.
module tb_cache_write_combine_ctrl;

   logic         clk = 1'b0;
   logic         rstn;
   logic         p_req;
   logic         p_ready;
   logic [31:0]  p_addr;
   logic [3:0]   p_w_en;
   logic [31:0]  p_wdata;
   logic         flush;
   logic         idle;
   logic         m_valid;
   logic         m_ready;
   logic [31:0]  m_addr;
   logic [127:0] m_data;
   logic [15:0]  m_strb;

   int checks   = 0;
   int failures = 0;

   cache_write_combine_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .p_req(p_req), .p_ready(p_ready), .p_addr(p_addr),
      .p_w_en(p_w_en), .p_wdata(p_wdata), .flush(flush), .idle(idle),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
      .m_strb(m_strb)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      p_req = 1'b1; p_addr = a; p_w_en = m; p_wdata = d;
   endtask

   task automatic quiet();
      p_req = 1'b0; p_w_en = 4'h0; p_addr = 32'h0; p_wdata = 32'h0; flush = 1'b0;
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      quiet();
      m_ready = 1'b0;
      rstn = 1'b0;
      #12;
      checks++;
      if (m_valid !== 1'b0 || idle !== 1'b1 || m_addr !== 32'h0 || m_data !== 128'h0 || m_strb !== 16'h0) begin
         failures++;
         $display("FAIL reset_state: m_valid=%b idle=%b m_addr=%h m_strb=%h m_data=%h", m_valid, idle, m_addr, m_strb, m_data);
      end
      @(negedge clk);
      rstn = 1'b1;
      step();
   endtask

   task automatic test_full_line();
      store(32'h100, 4'hF, 32'hA0); step();
      store(32'h104, 4'hF, 32'hA1); step();
      store(32'h108, 4'hF, 32'hA2); step();
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_early_valid: m_valid=%b expected 0", m_valid);
      end
      store(32'h10C, 4'hF, 32'hA3); step();
      quiet();
      checks++;
      if (m_valid !== 1'b1 || m_addr !== 32'h100 || m_strb !== 16'hFFFF ||
          m_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         failures++;
         $display("FAIL full_line: m_valid=%b m_addr=%h m_strb=%h m_data=%h", m_valid, m_addr, m_strb, m_data);
      end
      handshake();
      checks++;
      if (m_valid !== 1'b0 || idle !== 1'b1) begin
         failures++;
         $display("FAIL full_release: m_valid=%b idle=%b expected 0/1", m_valid, idle);
      end
   endtask

   task automatic test_merge_flush();
      store(32'h204, 4'b0011, 32'h1122_3344); step();
      store(32'h204, 4'b1100, 32'h5566_7788); step();
      quiet(); flush = 1'b1; step();
      flush = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_addr !== 32'h200 || m_strb !== 16'h00F0 ||
          m_data !== 128'h00000000_00000000_55663344_00000000) begin
         failures++;
         $display("FAIL merge_flush: m_valid=%b m_addr=%h m_strb=%h m_data=%h", m_valid, m_addr, m_strb, m_data);
      end
      handshake();
   endtask

   task automatic test_line_change();
      store(32'h300, 4'hF, 32'hDEAD_BEEF); step();
      store(32'h400, 4'hF, 32'h1234_5678);
      #1;
      checks++;
      if (p_ready !== 1'b0) begin
         failures++;
         $display("FAIL mismatch_ready: p_ready=%b expected 0", p_ready);
      end
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_addr !== 32'h300 || m_strb !== 16'h000F ||
             m_data !== 128'hDEADBEEF || p_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_stall_%0d: m_valid=%b m_addr=%h m_strb=%h m_data=%h p_ready=%b",
                     i, m_valid, m_addr, m_strb, m_data, p_ready);
         end
         step();
      end
      handshake();
      checks++;
      if (idle !== 1'b1 || p_ready !== 1'b1 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_reentry: idle=%b p_ready=%b m_valid=%b expected 1/1/0", idle, p_ready, m_valid);
      end
      step();
      quiet(); flush = 1'b1;
      checks++;
      if (idle !== 1'b0) begin
         failures++;
         $display("FAIL held_store_accept: idle=%b expected 0", idle);
      end
      step();
      flush = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_addr !== 32'h400 || m_strb !== 16'h000F || m_data !== 128'h12345678) begin
         failures++;
         $display("FAIL second_line: m_valid=%b m_addr=%h m_strb=%h m_data=%h", m_valid, m_addr, m_strb, m_data);
      end
      handshake();
   endtask

   task automatic test_timeout();
      int seen;
      store(32'h50C, 4'h1, 32'h0000_00EE); step();
      quiet();
      seen = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (m_valid === 1'b1 && seen == 0) seen = k;
         if (seen != 0) break;
      end
      checks++;
      if (seen != 16 || m_strb !== 16'h1000 || m_addr !== 32'h500 ||
          m_data !== 128'h000000EE_00000000_00000000_00000000) begin
         failures++;
         $display("FAIL timeout_single: cycles=%0d expected 16 m_strb=%h m_addr=%h m_data=%h", seen, m_strb, m_addr, m_data);
      end
      handshake();
      step();
      store(32'h50C, 4'h1, 32'h0000_00EE); step();
      quiet();
      repeat (9) step();
      store(32'h50C, 4'h2, 32'h0000_DD00); step();
      quiet();
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_restart_early: m_valid=%b expected 0", m_valid);
      end
      seen = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (m_valid === 1'b1 && seen == 0) seen = k;
         if (seen != 0) break;
      end
      checks++;
      if (seen != 16 || m_strb !== 16'h3000 || m_data !== 128'h0000DDEE_00000000_00000000_00000000) begin
         failures++;
         $display("FAIL timeout_restart: cycles=%0d expected 16 m_strb=%h m_data=%h", seen, m_strb, m_data);
      end
      handshake();
   endtask

   task automatic test_reset_in_drain();
      store(32'h600, 4'hF, 32'hCAFE_F00D); flush = 1'b1; step();
      quiet();
      checks++;
      if (idle !== 1'b0 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_entry: idle=%b m_valid=%b expected 0/0", idle, m_valid);
      end
      step();
      checks++;
      if (m_valid !== 1'b1 || m_addr !== 32'h600 || m_strb !== 16'h000F) begin
         failures++;
         $display("FAIL flush_entry_drain: m_valid=%b m_addr=%h m_strb=%h", m_valid, m_addr, m_strb);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_addr !== 32'h0 || m_data !== 128'h0 || m_strb !== 16'h0 || idle !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_drain: m_valid=%b m_addr=%h m_strb=%h m_data=%h idle=%b", m_valid, m_addr, m_strb, m_data, idle);
      end
      m_ready = 1'b1;
      step();
      @(negedge clk);
      rstn = 1'b1;
      step();
      m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || idle !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: m_valid=%b idle=%b expected 0/1", m_valid, idle);
      end
   endtask

   task automatic test_idle_noops();
      quiet(); flush = 1'b1; step();
      flush = 1'b0;
      checks++;
      if (idle !== 1'b1 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_flush: idle=%b m_valid=%b expected 1/0", idle, m_valid);
      end
      store(32'h700, 4'h0, 32'hFFFF_FFFF);
      #1;
      checks++;
      if (p_ready !== 1'b1) begin
         failures++;
         $display("FAIL idle_ready: p_ready=%b expected 1", p_ready);
      end
      step();
      quiet();
      repeat (3) step();
      checks++;
      if (idle !== 1'b1 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_empty_mask: idle=%b m_valid=%b expected 1/0", idle, m_valid);
      end
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_merge_flush();
      test_line_change();
      test_timeout();
      test_reset_in_drain();
      test_idle_noops();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
